// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: FSM states and default ZX-Uno register addresses for the PS/2 host transmitter
package ps2_host_tx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_BITS, S_ACK, S_WAIT} state_t;
    localparam logic [7:0] DATA_ADDR_DEF = 8'hF0;
    localparam logic [7:0] STAT_ADDR_DEF = 8'hF1;
endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// ps2_host_tx_line_sync: 2-FF synchroniser plus stability filter on a PS/2 line, with a one-cycle fall pulse
module ps2_host_tx_line_sync #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            fall <= 1'b0;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CW'(FILT_LEN - 1)) begin
                level <= sync[1];
                fall  <= level;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command sender on ZX-Uno registers; define PS2TX_AUTORETRY_EN for one automatic resend
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter logic [7:0] DATA_ADDR   = DATA_ADDR_DEF,
    parameter logic [7:0] STAT_ADDR   = STAT_ADDR_DEF,
    parameter int         INHIBIT_CYC = 3360,
    parameter int         TIMEOUT_CYC = 420000,
    parameter int         FILT_LEN    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_pull,
    output logic       ps2data_pull,
    output logic       busy
);
    localparam int TW = $clog2((TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC) + 1);
`ifdef PS2TX_AUTORETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif
    state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0] nbit, nbit_n;
    logic [7:0] data, data_n;
    logic par, par_n, dpull, dpull_n;
    logic ack, ack_n, tmo_f, tmo_n, nack, nack_n, drop, drop_n, rtry, rtry_n;
    logic [1:0] dsync;
    logic clk_f, fall, data_s, wr, rd_stat, tmo, acked, nacked;

    ps2_host_tx_line_sync #(.FILT_LEN(FILT_LEN)) u_clk_sync (
        .clk(clk), .rst_n(rst_n), .raw(ps2clk_in), .level(clk_f), .fall(fall)
    );

    assign data_s       = dsync[1];
    assign busy         = state != S_IDLE;
    assign wr           = zxuno_regwr && zxuno_addr == DATA_ADDR;
    assign rd_stat      = zxuno_regrd && zxuno_addr == STAT_ADDR;
    assign oe_n         = !(zxuno_regrd && (zxuno_addr == DATA_ADDR || zxuno_addr == STAT_ADDR));
    assign dout         = oe_n ? 8'h00 : zxuno_addr == DATA_ADDR ? data : {2'b00, rtry, drop, nack, tmo_f, ack, busy};
    assign ps2clk_pull  = state == S_INHIBIT;
    assign ps2data_pull = dpull;
    assign tmo          = (state == S_BITS || state == S_ACK) && timer >= TW'(TIMEOUT_CYC);
    assign acked        = state == S_ACK && fall && !data_s && !tmo;
    assign nacked       = state == S_ACK && fall && data_s && !tmo;

    always_comb begin
        state_n = state;
        timer_n = &timer ? timer : timer + 1'b1;
        nbit_n  = nbit;
        data_n  = data;
        par_n   = par;
        dpull_n = dpull;
        ack_n   = ack;
        tmo_n   = tmo_f;
        nack_n  = nack;
        rtry_n  = rtry;
        drop_n  = (drop && !rd_stat) || (wr && busy);
        case (state)
            S_IDLE: if (wr) begin
                data_n  = din;
                par_n   = ~^din;
                {ack_n, tmo_n, nack_n, rtry_n} = '0;
                timer_n = '0;
                state_n = S_INHIBIT;
            end
            S_INHIBIT: if (timer == TW'(INHIBIT_CYC - 1)) begin
                dpull_n = 1'b1;
                nbit_n  = '0;
                timer_n = '0;
                state_n = S_BITS;
            end
            S_BITS: if (fall) begin
                nbit_n  = nbit + 1'b1;
                dpull_n = nbit < 4'd8 ? ~data[nbit[2:0]] : nbit == 4'd8 ? ~par : 1'b0;
                state_n = nbit == 4'd9 ? S_ACK : S_BITS;
            end
            S_WAIT: begin
                timer_n = clk_f && data_s ? timer + 1'b1 : '0;
                if (clk_f && data_s && timer == TW'(FILT_LEN - 1))
                    state_n = S_IDLE;
            end
            default: ;
        endcase
        if (acked) begin
            ack_n   = 1'b1;
            timer_n = '0;
            state_n = S_WAIT;
        end
        // A failed attempt either restarts from inhibit once or reports the error
        if (tmo || nacked) begin
            dpull_n = 1'b0;
            timer_n = '0;
            if (RETRY && !rtry) begin
                rtry_n  = 1'b1;
                state_n = S_INHIBIT;
            end else begin
                tmo_n   = tmo_f || tmo;
                nack_n  = nack || nacked;
                state_n = tmo ? S_IDLE : S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
            nbit  <= '0;
            data  <= '0;
            par   <= 1'b0;
            dpull <= 1'b0;
            ack   <= 1'b0;
            tmo_f <= 1'b0;
            nack  <= 1'b0;
            drop  <= 1'b0;
            rtry  <= 1'b0;
            dsync <= 2'b11;
        end else begin
            state <= state_n;
            timer <= timer_n;
            nbit  <= nbit_n;
            data  <= data_n;
            par   <= par_n;
            dpull <= dpull_n;
            ack   <= ack_n;
            tmo_f <= tmo_n;
            nack  <= nack_n;
            drop  <= drop_n;
            rtry  <= rtry_n;
            dsync <= {dsync[0], ps2data_in};
        end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 keyboard model plus frame/status scoreboard for ps2_host_tx
module tb_ps2_host_tx;
    localparam int INH = 200, TMO = 3000, FL = 8;
    localparam logic [7:0] DA = 8'hF0, SA = 8'hF1;
    localparam int M_ACK = 0, M_NACK = 1, M_NOCLK = 2;
`ifdef PS2TX_AUTORETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] zxuno_addr = 8'h00, din = 8'h00, dout;
    logic zxuno_regrd = 1'b0, zxuno_regwr = 1'b0, oe_n;
    logic ps2clk_pull, ps2data_pull, busy, ps2clk_in, ps2data_in;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
    int checks = 0, errors = 0;
    int dev_mode = M_ACK, half = 40;
    bit abort = 1'b0;
    logic [10:0] exp_frames[$];

    assign ps2clk_in  = !(ps2clk_pull || dev_clk_low);
    assign ps2data_in = !(ps2data_pull || dev_data_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe_n(oe_n),
        .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in), .ps2clk_pull(ps2clk_pull),
        .ps2data_pull(ps2data_pull), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Wire order: start, d0..d7, odd parity, stop
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        logic p;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        p = (ones % 2) == 0;
        return {1'b1, p, b, 1'b0};
    endfunction

    function automatic logic [7:0] exp_status(input int mode, input bit dropped);
        logic [7:0] s;
        s = mode == M_ACK ? 8'h02 : mode == M_NACK ? 8'h08 : 8'h04;
        if (RETRY && mode != M_ACK) s |= 8'h20;
        if (dropped) s |= 8'h10;
        return s;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        zxuno_addr = a; din = d; zxuno_regwr = 1'b1;
        @(negedge clk);
        zxuno_regwr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic o);
        @(negedge clk);
        zxuno_addr = a; zxuno_regrd = 1'b1;
        #1 d = dout; o = oe_n;
        @(negedge clk);
        zxuno_regrd = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int mode, input bit dup);
        int n, cyc, mult;
        logic [7:0] v;
        logic o;
        dev_mode = mode;
        n = mode == M_NOCLK ? 0 : (RETRY && mode == M_NACK) ? 2 : 1;
        for (int i = 0; i < n; i++) exp_frames.push_back(exp_frame(b));
        bus_write(DA, b);
        chk("busy_after_write", busy, 1);
        if (dup) begin
            repeat (100) @(negedge clk);
            bus_write(DA, ~b);
        end
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_in_budget", busy, 0);
        chk("lines_released", {ps2clk_pull, ps2data_pull}, 0);
        if (mode == M_NOCLK) begin
            mult = RETRY ? 2 : 1;
            chk("timeout_span", cyc >= mult * (INH + TMO) - 5 && cyc <= mult * (INH + TMO) + 50, 1);
        end
        repeat (150) @(negedge clk);
        chk("frames_all_seen", exp_frames.size(), 0);
        exp_frames.delete();
        bus_read(SA, v, o);
        chk("status", v, exp_status(mode, dup));
        chk("oe_n_stat", o, 0);
        if (dup) begin
            bus_read(SA, v, o);
            chk("status_after_clear", v, exp_status(mode, 1'b0));
        end
        bus_read(DA, v, o);
        chk("data_reg", v, b);
    endtask

    // Every host inhibit must hold the clock low for at least INH cycles
    initial begin : inhibit_mon
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (ps2clk_pull) run++;
            else begin
                if (run > 0) chk("inhibit_len", run >= INH, 1);
                run = 0;
            end
        end
    end

    // Keyboard model: clocks the frame after an inhibit/release and checks it against the queue
    initial begin : device
        logic [10:0] f;
        int h;
        forever begin
            @(negedge clk);
            while (!ps2clk_pull) @(negedge clk);
            while (ps2clk_pull) @(negedge clk);
            if (dev_mode != M_NOCLK) begin
                h = half;
                repeat (20) @(negedge clk);
                f = '0;
                f[0] = ps2data_in;
                for (int i = 1; i <= 11 && !abort; i++) begin
                    dev_data_low = i == 11 && dev_mode == M_ACK;
                    dev_clk_low = 1'b1;
                    repeat (h) @(negedge clk);
                    if (i <= 10) f[i] = ps2data_in;
                    dev_clk_low = 1'b0;
                    repeat (h) @(negedge clk);
                    dev_data_low = 1'b0;
                end
                if (abort) begin
                    dev_clk_low = 1'b0;
                    dev_data_low = 1'b0;
                    abort = 1'b0;
                end else if (exp_frames.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%b expected=none", f);
                end else
                    chk("frame", f, exp_frames.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] v;
        logic o;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_pulls", {ps2clk_pull, ps2data_pull}, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_read(SA, v, o);
        chk("rst_status", v, 0);
        chk("oe_n_stat", o, 0);
        bus_read(DA, v, o);
        chk("rst_data", v, 0);
        bus_read(8'h00, v, o);
        chk("oe_n_other", o, 1);
        chk("dout_other", v, 0);
        send(8'hED, M_ACK, 1'b0);
        send(8'h00, M_ACK, 1'b0);
        send(8'hFF, M_ACK, 1'b0);
        send(8'h3C, M_NOCLK, 1'b0);
        send(8'h96, M_NACK, 1'b0);
        send(8'hA5, M_ACK, 1'b1);
        dev_mode = M_ACK;
        exp_frames.push_back(exp_frame(8'h3C));
        bus_write(DA, 8'h3C);
        repeat (INH + 20 + 8 * half) @(negedge clk);
        chk("busy_mid_frame", busy, 1);
        abort = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_pulls", {ps2clk_pull, ps2data_pull}, 0);
        chk("rst_mid_busy", busy, 0);
        exp_frames.delete();
        for (int i = 0; i < 500 && abort; i++) @(negedge clk);
        chk("device_abort_done", abort, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(SA, v, o);
        chk("status_after_rst", v, 0);
        send(8'h5A, M_ACK, 1'b0);
        for (int k = 0; k < 10; k++) begin
            half = $urandom_range(30, 45);
            send(8'($urandom), $urandom_range(0, 3) == 0 ? M_NACK : M_ACK, k == 3);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
